// File: rtl/rv_pkg.sv
// Shared RV constants: load funct3 encodings, default data width and the zero register.
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_W        = 5;

  localparam logic [REG_W-1:0] REG_X0 = 5'd0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a returned load word and sign/zero-extends it.
module load_extend
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] ext_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = data[7:0];
    case (addr_lo)
      2'd1:    byte_v = data[15:8];
      2'd2:    byte_v = data[23:16];
      2'd3:    byte_v = data[31:24];
      default: byte_v = data[7:0];
    endcase
    // Halfword alignment uses only addr_lo[1]; misalignment is handled upstream.
    half_v = addr_lo[1] ? data[31:16] : data[15:0];

    ext_c = data;
    case (funct3)
      F3_LB:   ext_c = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  ext_c = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   ext_c = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  ext_c = {{(XLEN-16){1'b0}}, half_v};
      default: ext_c = data;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port arbiter: retires loads and buffered ALU results, one per cycle,
// and reports in-flight destinations to decode for hazard stalls.
module writeback_unit
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [4:0]       ld_rd,
  input  logic [2:0]       ld_funct3,
  input  logic [1:0]       ld_addr_lo,
  input  logic [XLEN-1:0]  ld_data,
  output logic             regWrite,
  output logic [4:0]       writeReg,
  output logic [XLEN-1:0]  writeData,
  input  logic [4:0]       q_rs1,
  input  logic [4:0]       q_rs2,
  output logic             hazard1,
  output logic             hazard2
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            ld_fire;
  logic            alu_fire;
  logic            sel_ld;
  logic            sel_pop;
  logic            sel_byp;
  logic            push;
  logic            ret_valid;
  logic [4:0]      ret_rd;
  logic [XLEN-1:0] ret_data;
  logic [XLEN-1:0] ld_ext;
  logic            fifo_hit1;
  logic            fifo_hit2;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .data    (ld_data),
    .ext_c   (ld_ext)
  );

  // A full FIFO stalls loads too, so the head is guaranteed to drain.
  assign full      = (count == CW'(DEPTH));
  assign alu_ready = ~full;
  assign ld_ready  = ~full;

  // Retire priority: accepted load, then FIFO head, then ALU bypass into an empty FIFO.
  always_comb begin
    ld_fire   = ld_valid & ld_ready;
    alu_fire  = alu_valid & alu_ready;
    sel_ld    = ld_fire;
    sel_pop   = ~ld_fire & (count != '0);
    sel_byp   = ~ld_fire & (count == '0) & alu_fire;
    push      = alu_fire & ~sel_byp;
    ret_valid = sel_ld | sel_pop | sel_byp;
    ret_rd    = alu_rd;
    ret_data  = alu_data;
    if (sel_ld) begin
      ret_rd   = ld_rd;
      ret_data = ld_ext;
    end else if (sel_pop) begin
      ret_rd   = fifo_rd[rd_ptr];
      ret_data = fifo_data[rd_ptr];
    end
  end

  // Pending-destination match over occupied FIFO slots, oldest first.
  always_comb begin
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (fifo_rd[rd_ptr + PW'(i)] == q_rs1) fifo_hit1 = 1'b1;
        if (fifo_rd[rd_ptr + PW'(i)] == q_rs2) fifo_hit2 = 1'b1;
      end
    end
  end

  assign hazard1 = (q_rs1 != REG_X0) &
                   (fifo_hit1 | (alu_valid & (alu_rd == q_rs1)) | (ld_valid & (ld_rd == q_rs1)));
  assign hazard2 = (q_rs2 != REG_X0) &
                   (fifo_hit2 | (alu_valid & (alu_rd == q_rs2)) | (ld_valid & (ld_rd == q_rs2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      if (push) begin
        fifo_rd[wr_ptr]   <= alu_rd;
        fifo_data[wr_ptr] <= alu_data;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (sel_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(sel_pop);

      // x0 writes are consumed but never enabled on the register file.
      regWrite <= ret_valid & (ret_rd != REG_X0);
      if (ret_valid) begin
        writeReg  <= ret_rd;
        writeData <= ret_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_writeback_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_data;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  q_rs1, q_rs2;
  logic        hazard1, hazard2;

  int checks = 0;
  int errors = 0;

  writeback_unit #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .ld_data(ld_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .hazard1(hazard1), .hazard2(hazard2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load extension from shift/mask arithmetic.
  function automatic logic [31:0] ext_model(input logic [2:0] f, input logic [1:0] a,
                                            input logic [31:0] d);
    logic [31:0] v;
    case (f)
      3'b000: begin v = (d >> (8 * a)) & 32'hFF;  if (v[7])  v = v | 32'hFFFF_FF00; end
      3'b100: v = (d >> (8 * a)) & 32'hFF;
      3'b001: begin v = (d >> (16 * a[1])) & 32'hFFFF; if (v[15]) v = v | 32'hFFFF_0000; end
      3'b101: v = (d >> (16 * a[1])) & 32'hFFFF;
      default: v = d;
    endcase
    return v;
  endfunction

  typedef struct { logic [4:0] rd; logic [31:0] data; } res_t;
  res_t        mq[$];
  logic        e_we = 1'b0;
  logic [4:0]  e_rd = '0;
  logic [31:0] e_data = '0;
  bit          armed = 0;

  function automatic logic hz_model(input logic [4:0] r);
    logic hit;
    hit = (alu_valid && alu_rd == r) || (ld_valid && ld_rd == r);
    foreach (mq[i]) if (mq[i].rd == r) hit = 1'b1;
    return (r != 5'd0) && hit;
  endfunction

  // Model step at each edge from the stable inputs, then compare once outputs settle.
  always @(posedge clk) begin
    bit full, lf, af, byp;
    res_t e;
    if (rst) begin
      mq.delete();
      e_we = 1'b0; e_rd = '0; e_data = '0;
      armed = 1;
    end else begin
      full = (mq.size() == DEPTH);
      lf   = ld_valid && !full;
      af   = alu_valid && !full;
      byp  = 0;
      e_we = 1'b0;
      if (lf) begin
        e_rd = ld_rd; e_data = ext_model(ld_funct3, ld_addr_lo, ld_data); e_we = (ld_rd != 0);
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        e_rd = e.rd; e_data = e.data; e_we = (e.rd != 0);
      end else if (af) begin
        e_rd = alu_rd; e_data = alu_data; e_we = (alu_rd != 0); byp = 1;
      end
      if (af && !byp) begin
        e.rd = alu_rd; e.data = alu_data;
        mq.push_back(e);
      end
    end
    #1;
    if (armed) begin
      chk("m_regWrite", 32'(regWrite), 32'(e_we));
      chk("m_writeReg", 32'(writeReg), 32'(e_rd));
      chk("m_writeData", writeData, e_data);
      chk("m_alu_ready", 32'(alu_ready), 32'(mq.size() != DEPTH));
      chk("m_ld_ready", 32'(ld_ready), 32'(mq.size() != DEPTH));
      chk("m_hazard1", 32'(hazard1), 32'(hz_model(q_rs1)));
      chk("m_hazard2", 32'(hazard2), 32'(hz_model(q_rs2)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [2:0]  sw_f3 [4];
  logic [1:0]  sw_a  [4];
  logic [31:0] sw_exp[4];

  initial begin
    bit aacc, lacc, ok;
    rst = 1; alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hDEAD;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0; ld_data = 0;
    q_rs1 = 5'd1; q_rs2 = 5'd2;

    // Reset with a live ALU offer.
    tick(); tick();
    rst = 0; idle(); #1;
    chk("rst_regWrite", 32'(regWrite), 0);
    chk("rst_alu_ready", 32'(alu_ready), 1);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    chk("rst_hazard1", 32'(hazard1), 0);
    chk("rst_hazard2", 32'(hazard2), 0);

    // ALU bypass, latency 1.
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick(); idle();
    chk("byp_we", 32'(regWrite), 1);
    chk("byp_rd", 32'(writeReg), 5);
    chk("byp_data", writeData, 32'h1234);
    tick();
    chk("byp_idle_we", 32'(regWrite), 0);
    chk("byp_hold_rd", 32'(writeReg), 5);

    // Load and ALU together: load first, ALU from the FIFO next.
    ld_valid = 1; ld_rd = 5'd7; ld_funct3 = 3'b000; ld_addr_lo = 2'd3; ld_data = 32'h80FF_FF00;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'hA;
    tick(); idle();
    chk("cf_ld_rd", 32'(writeReg), 7);
    chk("cf_ld_data", writeData, 32'hFFFF_FF80);
    tick();
    chk("cf_alu_rd", 32'(writeReg), 9);
    chk("cf_alu_data", writeData, 32'hA);

    // Extension sweep.
    sw_f3[0] = 3'b100; sw_a[0] = 2'd2; sw_exp[0] = 32'h0000_0001;
    sw_f3[1] = 3'b001; sw_a[1] = 2'd2; sw_exp[1] = 32'hFFFF_8001;
    sw_f3[2] = 3'b101; sw_a[2] = 2'd0; sw_exp[2] = 32'h0000_7F02;
    sw_f3[3] = 3'b010; sw_a[3] = 2'd0; sw_exp[3] = 32'h8001_7F02;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_rd = 5'(10 + i); ld_funct3 = sw_f3[i]; ld_addr_lo = sw_a[i];
      ld_data = 32'h8001_7F02;
      tick();
      chk("ext_data", writeData, sw_exp[i]);
      chk("ext_rd", 32'(writeReg), 32'(10 + i));
    end
    idle(); tick();

    // Full FIFO with a load held valid throughout.
    ld_valid = 1; ld_rd = 5'd12; ld_funct3 = 3'b010; ld_addr_lo = 0; ld_data = 32'h55;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(16 + i); alu_data = 32'(32'h110 + i);
      tick();
    end
    chk("full_alu_ready", 32'(alu_ready), 0);
    chk("full_ld_ready", 32'(ld_ready), 0);
    alu_rd = 5'd20; alu_data = 32'h114;
    tick();
    chk("full_pop_rd", 32'(writeReg), 16);
    chk("full_pop_data", writeData, 32'h110);
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      aacc = alu_ready;
      tick();
      ok = aacc;
    end
    if (!ok) begin errors++; checks++; $display("FAIL full_accept: got no accept expected accept"); end
    idle();
    for (int n = 0; n < 8; n++) tick();

    // x0 consumed silently; queued x3 flags hazard until its retire.
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h77; q_rs1 = 5'd0; #1;
    chk("x0_hazard1", 32'(hazard1), 0);
    tick(); idle();
    chk("x0_we", 32'(regWrite), 0);
    ld_valid = 1; ld_rd = 5'd4; ld_funct3 = 3'b010; ld_data = 32'h44;
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
    tick(); idle(); q_rs1 = 5'd3; #1;
    chk("x3_hazard_q", 32'(hazard1), 1);
    tick();
    chk("x3_retire_rd", 32'(writeReg), 3);
    chk("x3_retire_we", 32'(regWrite), 1);
    chk("x3_hazard_done", 32'(hazard1), 0);

    // Reset mid-operation drops the buffered result.
    ld_valid = 1; ld_rd = 5'd21; alu_valid = 1; alu_rd = 5'd22; alu_data = 32'h22;
    tick(); idle();
    rst = 1; tick(); rst = 0;
    chk("mid_rst_we", 32'(regWrite), 0);
    tick();
    chk("mid_rst_dropped", 32'(regWrite), 0);

    // Mixed traffic under flow control.
    for (int c = 0; c < 40; c++) begin
      if (!alu_valid && (c % 3 != 2)) begin
        alu_valid = 1; alu_rd = 5'(c % 8); alu_data = 32'(c * 32'h1111);
      end
      if (!ld_valid && (c % 4 == 1)) begin
        ld_valid = 1; ld_rd = 5'(c); ld_funct3 = 3'(c % 8); ld_addr_lo = 2'(c);
        ld_data = 32'h8BAD_F00D ^ 32'(c << 7);
      end
      q_rs1 = 5'(c % 8); q_rs2 = 5'(c % 5);
      aacc = alu_valid && alu_ready;
      lacc = ld_valid && ld_ready;
      tick();
      if (aacc) alu_valid = 0;
      if (lacc) ld_valid = 0;
    end
    idle();
    for (int n = 0; n < 8; n++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writer side of the register-file write port (regWrite / writeReg / writeData) that feeds the decode stage's register file.
- Collects results from two producers:
  - single-cycle ALU results, buffered in an in-order FIFO;
  - load data returning from memory, which is aligned and sign/zero-extended here.
- Retires at most one register write per cycle.
- Exposes a pending-destination check so decode can stall on RAW/WAW hazards.

Parameters:
- XLEN, 32, data width.
- DEPTH, 4, ALU result FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  FIFO can accept
- alu_rd  in  5  destination register
- alu_data  in  XLEN  result
- ld_valid  in  1  load data offered
- ld_ready  out  1  load accepted this cycle when high with ld_valid
- ld_rd  in  5  destination register
- ld_funct3  in  3  load type (LB/LH/LW/LBU/LHU encoding)
- ld_addr_lo  in  2  byte offset of the load address
- ld_data  in  XLEN  raw aligned memory word
- regWrite  out  1  register-file write enable
- writeReg  out  5  register-file write address
- writeData  out  XLEN  register-file write data
- q_rs1  in  5  decode source register 1 query
- q_rs2  in  5  decode source register 2 query
- hazard1  out  1  q_rs1 has a write in flight
- hazard2  out  1  q_rs2 has a write in flight

Behaviour:
- Reset (rst=1 at a clk edge): FIFO emptied (rd/wr pointers and count = 0); regWrite=0, writeReg=0, writeData=0. Reset mid-operation drops all buffered and in-flight results.
- Handshakes:
  - ALU transfer occurs when alu_valid & alu_ready.
  - Load transfer occurs when ld_valid & ld_ready.
  - Producers must hold valid and payload stable until accepted.
  - alu_ready = (count != DEPTH).
  - ld_ready = (count != DEPTH). When the FIFO is full, the load is stalled so the FIFO drains.
- Retire selection, once per cycle, in priority order:
  1. An accepted load retires.
  2. Otherwise, the FIFO head pops if count > 0.
  3. Otherwise, an accepted ALU result with count == 0 bypasses the FIFO.
  - An accepted ALU result that does not retire this cycle is pushed.
  - Push and pop may occur in the same cycle; count is then unchanged.
- Outputs are registered. The selected result appears on regWrite/writeReg/writeData at the next clk edge, so minimum latency is 1 cycle. With no candidate, regWrite=0 and writeReg/writeData hold their previous values.
- Register x0: a result with rd == 0 is consumed normally (handshake and FIFO slot) but produces regWrite=0 on its retire cycle.
- Load extension (selected by ld_funct3):
  - 000 LB: byte ld_data[8*addr_lo +: 8], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half ld_data[16*addr_lo[1] +: 16], sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW and all other codes: ld_data unchanged.
  - addr_lo[0] is ignored for halfwords; misalignment is not this block's responsibility.
- Ordering: ALU results retire in acceptance order. Ordering between loads and ALU results is not guaranteed; decode prevents WAW via the hazard outputs.
- Hazards (combinational), for each q_rsN:
  - hazardN = (q_rsN != 0) & (match against any valid FIFO entry's rd, or alu_valid & alu_rd, or ld_valid & ld_rd).
  - The output stage is excluded: the register file writes at this clk edge.
- Simultaneous events: load and ALU accepted with an empty FIFO → the load retires and the ALU result is pushed (count becomes 1).

Decomposition:
- Shared package (rv_pkg):
  - funct3 load constants: F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
  - XLEN default and the REG_X0 constant.
- One natural sub-module: load_extend, purely combinational (funct3, addr_lo, data → extended word). Unit-testable on its own.
- The FIFO is kept inline, as a circular buffer with a count.

Test Plan:
- Reset: drive rst=1 for 2 cycles with alu_valid=1 → regWrite=0, alu_ready=1, ld_ready=1, hazard1=hazard2=0 afterwards.
- ALU bypass: alu rd=5, data=0x1234 with the FIFO empty → next cycle regWrite=1, writeReg=5, writeData=0x1234; count stays 0.
- Conflict: same cycle, load (rd=7, LB, addr_lo=3, ld_data=0x80FF_FF00) and alu (rd=9, data=0xA) → cycle+1 writes x7=0xFFFF_FF80; cycle+2 writes x9=0xA.
- Extension sweep with ld_data=0x8001_7F02:
  - LBU addr_lo=2 → 0x01.
  - LH addr_lo=2 → 0xFFFF_8001.
  - LHU addr_lo=0 → 0x7F02.
  - LW → 0x8001_7F02.
- Full FIFO: hold ld_valid=1 continuously and push 5 ALU results →
  - alu_ready and ld_ready both 0 when count==4;
  - the next cycle pops the head in order;
  - no result is lost or reordered.
- x0 and hazards:
  - alu rd=0 → regWrite=0 on its retire cycle; hazard1=0 for q_rs1=0.
  - alu rd=3 queued → q_rs1=3 gives hazard1=1 until the retire cycle, then 0.
